// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer: single-request DDR4 initiator.
// Sequences ACT, RD/WR, PRE and moves one BL-beat burst.
module ddr4_cmd_sequencer #(
    parameter int RANKS        = 1,
    parameter int CHIPS        = 18,
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int TRCD         = 15,
    parameter int TCL          = 15,
    parameter int TCWL         = 11,
    parameter int TWR          = 12,
    parameter int TRP          = 15,
    parameter int CNTW         = 8,
    localparam int DQWIDTH     = DEVICE_WIDTH * CHIPS,
    localparam int RKW         = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [RKW-1:0]          req_rank,
    input  logic [BGWIDTH-1:0]      req_bg,
    input  logic [BAWIDTH-1:0]      req_ba,
    input  logic [ADDRWIDTH-1:0]    req_row,
    input  logic [COLWIDTH-1:0]     req_col,
    input  logic [DQWIDTH*BL-1:0]   req_wdata,
    output logic [DQWIDTH*BL-1:0]   rdata,
    output logic                    rdata_valid,
    output logic [RANKS-1:0]        cs_n,
    output logic                    act_n,
    output logic [ADDRWIDTH-1:0]    A,
    output logic [BGWIDTH-1:0]      bg,
    output logic [BAWIDTH-1:0]      ba,
    output logic [DQWIDTH-1:0]      dq_out,
    output logic                    dq_oe,
    input  logic [DQWIDTH-1:0]      dq_in,
    output logic [CHIPS-1:0]        dqs_t,
    output logic [CHIPS-1:0]        dqs_c
);

    localparam int BW = (BL > 1) ? $clog2(BL) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_TRCD_WAIT,
        S_CAS,
        S_LAT_WAIT,
        S_DATA,
        S_WR_RECOV,
        S_PRE,
        S_TRP_WAIT
    } state_t;

    state_t                  state_q;
    logic [CNTW-1:0]         cnt_q;
    logic [BW-1:0]           beat_q;

    logic                    wr_q;
    logic [RKW-1:0]          rank_q;
    logic [ADDRWIDTH-1:0]    row_q;
    logic [COLWIDTH-1:0]     col_q;
    logic [DQWIDTH*BL-1:0]   wdata_q;
    logic [DQWIDTH*BL-1:0]   rbuf_q;

    logic                    req_ready_q;
    logic [RANKS-1:0]        cs_n_q;
    logic                    act_n_q;
    logic [ADDRWIDTH-1:0]    a_q;
    logic [BGWIDTH-1:0]      bg_q;
    logic [BAWIDTH-1:0]      ba_q;
    logic [DQWIDTH-1:0]      dq_out_q;
    logic                    dq_oe_q;
    logic [CHIPS-1:0]        dqs_t_q;
    logic [CHIPS-1:0]        dqs_c_q;
    logic [DQWIDTH*BL-1:0]   rdata_q;
    logic                    rdata_valid_q;

    logic [ADDRWIDTH-1:0]    cas_a_d;
    logic [ADDRWIDTH-1:0]    pre_a_d;
    logic [DQWIDTH*BL-1:0]   rbuf_d;
    logic                    lat_one_d;
    logic [CNTW-1:0]         lat_ld_d;
    logic                    last_beat_d;

    // Active-low one-hot chip select; out-of-range ranks select nothing.
    function automatic logic [RANKS-1:0] cs_sel(input logic [RKW-1:0] r);
        for (int i = 0; i < RANKS; i++) begin
            cs_sel[i] = (r != RKW'(i));
        end
    endfunction

    // Command address words, read buffer merge and CAS latency choice.
    always_comb begin
        cas_a_d = '0;
        cas_a_d[COLWIDTH-1:0] = col_q;
        cas_a_d[10] = 1'b0;
        cas_a_d[16:14] = wr_q ? 3'b100 : 3'b101;
        pre_a_d = '0;
        pre_a_d[16:14] = 3'b010;
        rbuf_d = rbuf_q;
        rbuf_d[int'(beat_q)*DQWIDTH +: DQWIDTH] = dq_in;
        lat_one_d = wr_q ? (TCWL == 1) : (TCL == 1);
        lat_ld_d = wr_q ? CNTW'(TCWL - 2) : CNTW'(TCL - 2);
        last_beat_d = (beat_q == BW'(BL - 1));
    end

    // Sequencer FSM; every pin value is registered for the cycle it names.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            wr_q          <= 1'b0;
            rank_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            wdata_q       <= '0;
            rbuf_q        <= '0;
            req_ready_q   <= 1'b0;
            cs_n_q        <= '1;
            act_n_q       <= 1'b1;
            a_q           <= '0;
            bg_q          <= '0;
            ba_q          <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            dqs_t_q       <= '0;
            dqs_c_q       <= '1;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            cs_n_q        <= '1;
            act_n_q       <= 1'b1;
            a_q           <= '0;
            rdata_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    bg_q        <= '0;
                    ba_q        <= '0;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q    <= req_write;
                        rank_q  <= req_rank;
                        row_q   <= req_row;
                        col_q   <= req_col;
                        wdata_q <= req_wdata;
                        cs_n_q  <= cs_sel(req_rank);
                        act_n_q <= 1'b0;
                        a_q     <= req_row;
                        bg_q    <= req_bg;
                        ba_q    <= req_ba;
                        state_q <= S_ACT;
                    end
                end
                S_ACT, S_TRCD_WAIT: begin
                    if (state_q == S_ACT ? (TRCD == 1) : (cnt_q == '0)) begin
                        cs_n_q  <= cs_sel(rank_q);
                        a_q     <= cas_a_d;
                        state_q <= S_CAS;
                    end else if (state_q == S_ACT) begin
                        cnt_q   <= CNTW'(TRCD - 2);
                        state_q <= S_TRCD_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                S_CAS, S_LAT_WAIT: begin
                    if (state_q == S_CAS ? lat_one_d : (cnt_q == '0)) begin
                        beat_q  <= '0;
                        state_q <= S_DATA;
                        if (wr_q) begin
                            dq_oe_q  <= 1'b1;
                            dqs_t_q  <= '1;
                            dqs_c_q  <= '0;
                            dq_out_q <= wdata_q[DQWIDTH-1:0];
                        end
                    end else if (state_q == S_CAS) begin
                        cnt_q   <= lat_ld_d;
                        state_q <= S_LAT_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                S_DATA: begin
                    if (!last_beat_d) begin
                        beat_q <= beat_q + BW'(1);
                        if (wr_q) begin
                            dq_out_q <= wdata_q[(int'(beat_q) + 1)*DQWIDTH +: DQWIDTH];
                        end else begin
                            rbuf_q <= rbuf_d;
                        end
                    end else begin
                        beat_q <= '0;
                        if (wr_q) begin
                            dq_oe_q  <= 1'b0;
                            dq_out_q <= '0;
                            dqs_t_q  <= '0;
                            dqs_c_q  <= '1;
                            if (TWR == 0) begin
                                cs_n_q  <= cs_sel(rank_q);
                                a_q     <= pre_a_d;
                                state_q <= S_PRE;
                            end else begin
                                cnt_q   <= CNTW'(TWR - 1);
                                state_q <= S_WR_RECOV;
                            end
                        end else begin
                            rbuf_q        <= rbuf_d;
                            rdata_q       <= rbuf_d;
                            rdata_valid_q <= 1'b1;
                            cs_n_q        <= cs_sel(rank_q);
                            a_q           <= pre_a_d;
                            state_q       <= S_PRE;
                        end
                    end
                end
                S_WR_RECOV: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= cs_sel(rank_q);
                        a_q     <= pre_a_d;
                        state_q <= S_PRE;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                S_PRE: begin
                    bg_q <= '0;
                    ba_q <= '0;
                    if (TRP == 1) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q   <= CNTW'(TRP - 2);
                        state_q <= S_TRP_WAIT;
                    end
                end
                S_TRP_WAIT: begin
                    if (cnt_q == '0) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign cs_n        = cs_n_q;
    assign act_n       = act_n_q;
    assign A           = a_q;
    assign bg          = bg_q;
    assign ba          = ba_q;
    assign dq_out      = dq_out_q;
    assign dq_oe       = dq_oe_q;
    assign dqs_t       = dqs_t_q;
    assign dqs_c       = dqs_c_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// tb_ddr4_cmd_sequencer: directed bench with command/read scoreboards.
// A small DIMM model stores write bursts and returns them on reads.
module tb_ddr4_cmd_sequencer;

    localparam int DQW  = 72;
    localparam int BL   = 8;
    localparam int BW   = DQW * BL;
    localparam int TCL  = 15;
    localparam int TCWL = 11;
    localparam int MBW  = DQW * 2;
    localparam logic [DQW-1:0] JUNK = {9{8'hC3}};

    logic clk = 1'b0;
    logic reset;

    logic           req_valid, req_ready, req_write;
    logic [0:0]     req_rank;
    logic [1:0]     req_bg, req_ba;
    logic [16:0]    req_row;
    logic [9:0]     req_col;
    logic [BW-1:0]  req_wdata, rdata;
    logic           rdata_valid;
    logic [0:0]     cs_n;
    logic           act_n;
    logic [16:0]    A;
    logic [1:0]     bg, ba;
    logic [DQW-1:0] dq_out, dq_in;
    logic           dq_oe;
    logic [17:0]    dqs_t, dqs_c;

    logic           m_req_valid, m_req_ready, m_req_write;
    logic [0:0]     m_req_rank;
    logic [1:0]     m_req_bg, m_req_ba;
    logic [16:0]    m_req_row;
    logic [9:0]     m_req_col;
    logic [MBW-1:0] m_req_wdata, m_rdata;
    logic           m_rdata_valid;
    logic [0:0]     m_cs_n;
    logic           m_act_n;
    logic [16:0]    m_A;
    logic [1:0]     m_bg, m_ba;
    logic [DQW-1:0] m_dq_out, m_dq_in;
    logic           m_dq_oe;
    logic [17:0]    m_dqs_t, m_dqs_c;

    ddr4_cmd_sequencer #(
        .RANKS(1), .CHIPS(18), .BGWIDTH(2), .BAWIDTH(2),
        .ADDRWIDTH(17), .COLWIDTH(10), .DEVICE_WIDTH(4), .BL(BL),
        .TRCD(15), .TCL(TCL), .TCWL(TCWL), .TWR(12), .TRP(15), .CNTW(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_rank(req_rank),
        .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .dqs_t(dqs_t), .dqs_c(dqs_c)
    );

    ddr4_cmd_sequencer #(
        .RANKS(1), .CHIPS(18), .BGWIDTH(2), .BAWIDTH(2),
        .ADDRWIDTH(17), .COLWIDTH(10), .DEVICE_WIDTH(4), .BL(2),
        .TRCD(1), .TCL(1), .TCWL(1), .TWR(0), .TRP(1), .CNTW(8)
    ) dut_min (
        .clk(clk), .reset(reset),
        .req_valid(m_req_valid), .req_ready(m_req_ready),
        .req_write(m_req_write), .req_rank(m_req_rank),
        .req_bg(m_req_bg), .req_ba(m_req_ba),
        .req_row(m_req_row), .req_col(m_req_col),
        .req_wdata(m_req_wdata), .rdata(m_rdata),
        .rdata_valid(m_rdata_valid),
        .cs_n(m_cs_n), .act_n(m_act_n), .A(m_A),
        .bg(m_bg), .ba(m_ba),
        .dq_out(m_dq_out), .dq_oe(m_dq_oe), .dq_in(m_dq_in),
        .dqs_t(m_dqs_t), .dqs_c(m_dqs_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          t;
        logic        act_n;
        logic [16:0] a;
        logic [1:0]  bg;
        logic [1:0]  ba;
    } cmd_t;

    cmd_t          cmd_q[$];
    logic [BW-1:0] rd_q[$];

    task automatic chk(input string tag, input logic [639:0] obs,
                       input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int mk_key(logic [1:0] g, logic [1:0] b,
                                  logic [16:0] r, logic [9:0] c);
        return int'({g, b, r, c});
    endfunction

    function automatic logic [BW-1:0] fill(int key);
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) begin
            v[i*32 +: 32] = key ^ (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] rnd_line();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected pin commands for one request, timed from its accept cycle.
    task automatic push_cmds(input int t0, input bit w, input logic [1:0] g,
                             input logic [1:0] b, input logic [16:0] r,
                             input logic [9:0] c, input bit with_pre);
        logic [16:0] cas;
        cas = (w ? 17'h10000 : 17'h14000) | 17'(c);
        cmd_q.push_back('{t0 + 1, 1'b0, r, g, b});
        cmd_q.push_back('{t0 + 16, 1'b1, cas, g, b});
        if (with_pre) cmd_q.push_back('{t0 + (w ? 47 : 39), 1'b1, 17'h08000, g, b});
    endtask

    task automatic issue(input bit w, input logic [1:0] g, input logic [1:0] b,
                         input logic [16:0] r, input logic [9:0] c,
                         input logic [BW-1:0] wd, input bit with_pre,
                         output int t0);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("ready_wait", 640'(req_ready), 640'(1));
        req_write = w;
        req_rank  = 1'b0;
        req_bg    = g;
        req_ba    = b;
        req_row   = r;
        req_col   = c;
        req_wdata = wd;
        req_valid = 1'b1;
        t0 = cyc;
        push_cmds(t0, w, g, b, r, c, with_pre);
    endtask

    // Command and read-data scoreboard monitor.
    always @(negedge clk) begin
        cmd_t e;
        if (cs_n !== 1'b1) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", 640'(cmd_q.size()), 640'(1));
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_cycle", 640'(cyc), 640'(e.t));
                chk("cmd_act_n", 640'(act_n), 640'(e.act_n));
                chk("cmd_A", 640'(A), 640'(e.a));
                chk("cmd_bg", 640'(bg), 640'(e.bg));
                chk("cmd_ba", 640'(ba), 640'(e.ba));
            end
        end
        if (rdata_valid === 1'b1) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 640'(rd_q.size()), 640'(1));
            else chk("rdata", 640'(rdata), 640'(rd_q.pop_front()));
        end
    end

    // DIMM model: captures write bursts, returns stored or patterned reads.
    int            wr_at = -1000;
    int            rd_at = -1000;
    int            wr_key, rd_key;
    logic [16:0]   orow;
    logic [BW-1:0] wline, rline;
    logic [BW-1:0] mem [int];

    always @(negedge clk) begin
        if (reset) begin
            wr_at = -1000;
            rd_at = -1000;
            dq_in = JUNK;
        end else begin
            if (cs_n === 1'b0) begin
                if (act_n === 1'b0) orow = A;
                else if (A[16:14] == 3'b100) begin
                    wr_at = cyc;
                    wr_key = mk_key(bg, ba, orow, A[9:0]);
                end else if (A[16:14] == 3'b101) begin
                    rd_at = cyc;
                    rd_key = mk_key(bg, ba, orow, A[9:0]);
                end
            end
            if (cyc >= wr_at + TCWL && cyc < wr_at + TCWL + BL) begin
                wline[(cyc - wr_at - TCWL)*DQW +: DQW] = dq_out;
                if (cyc == wr_at + TCWL + BL - 1) mem[wr_key] = wline;
            end
            if (cyc >= rd_at + TCL && cyc < rd_at + TCL + BL) begin
                rline = mem.exists(rd_key) ? mem[rd_key] : fill(rd_key);
                dq_in = rline[(cyc - rd_at - TCL)*DQW +: DQW];
            end else begin
                dq_in = JUNK;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [BW-1:0]  wd1, wd2, wd3;
        logic [MBW-1:0] mline;
        bit oe;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_rank = 1'b0;
        req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
        req_wdata = '0;
        m_req_valid = 1'b0; m_req_write = 1'b0; m_req_rank = 1'b0;
        m_req_bg = '0; m_req_ba = '0; m_req_row = '0; m_req_col = '0;
        m_req_wdata = '0; m_dq_in = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_bg = 2'($urandom); req_ba = 2'($urandom);
            req_row = 17'($urandom); req_col = 10'($urandom);
            req_wdata = rnd_line();
            chk("rst_cs_n", 640'(cs_n), 640'(1));
            chk("rst_act_n", 640'(act_n), 640'(1));
            chk("rst_A", 640'(A), 640'(0));
            chk("rst_dq_oe", 640'(dq_oe), 640'(0));
            chk("rst_dq_out", 640'(dq_out), 640'(0));
            chk("rst_dqs_c", 640'(dqs_c), 640'(18'h3FFFF));
            chk("rst_dqs_t", 640'(dqs_t), 640'(0));
            chk("rst_rvalid", 640'(rdata_valid), 640'(0));
            chk("rst_rdata", 640'(rdata), 640'(0));
            chk("rst_ready", 640'(req_ready), 640'(0));
        end
        reset = 1'b0;
        req_valid = 1'b0;
        step();
        chk("ready_after_rst", 640'(req_ready), 640'(1));

        // Write W1: bg=1 ba=1 row=1 col=2
        wd1 = rnd_line();
        issue(1'b1, 2'd1, 2'd1, 17'd1, 10'd2, wd1, 1'b1, t0);
        for (int k = 1; k <= 62; k++) begin
            step();
            req_valid = 1'b0;
            oe = (k >= 27 && k <= 34);
            chk($sformatf("w1_oe_%0d", k), 640'(dq_oe), 640'(oe));
            chk($sformatf("w1_dqs_t_%0d", k), 640'(dqs_t), 640'(oe ? 18'h3FFFF : 18'h0));
            chk($sformatf("w1_dqs_c_%0d", k), 640'(dqs_c), 640'(oe ? 18'h0 : 18'h3FFFF));
            if (oe) chk($sformatf("w1_dq_%0d", k), 640'(dq_out), 640'(wd1[(k-27)*DQW +: DQW]));
            else chk($sformatf("w1_dq0_%0d", k), 640'(dq_out), 640'(0));
            chk($sformatf("w1_ready_%0d", k), 640'(req_ready), 640'(k == 62));
        end
        chk("w1_bg_idle", 640'(bg), 640'(0));
        chk("w1_ba_idle", 640'(ba), 640'(0));

        // Read W1 back
        rd_q.push_back(wd1);
        issue(1'b0, 2'd1, 2'd1, 17'd1, 10'd2, '0, 1'b1, t0);
        for (int k = 1; k <= 54; k++) begin
            step();
            req_valid = 1'b0;
            chk($sformatf("r1_rvalid_%0d", k), 640'(rdata_valid), 640'(k == 39));
            chk($sformatf("r1_ready_%0d", k), 640'(req_ready), 640'(k == 54));
            chk($sformatf("r1_oe_%0d", k), 640'(dq_oe), 640'(0));
        end

        // Back-pressure: valid held with changing fields
        rd_q.push_back(fill(mk_key(2'd2, 2'd3, 17'h1234, 10'h55)));
        issue(1'b0, 2'd2, 2'd3, 17'h1234, 10'h55, '0, 1'b1, t0);
        for (int k = 1; k <= 54; k++) begin
            step();
            req_bg = 2'($urandom); req_ba = 2'($urandom);
            req_row = 17'($urandom); req_col = 10'($urandom);
            chk($sformatf("bp_ready_%0d", k), 640'(req_ready), 640'(k == 54));
            if (k == 54) begin
                push_cmds(cyc, 1'b0, req_bg, req_ba, req_row, req_col, 1'b1);
                rd_q.push_back(fill(mk_key(req_bg, req_ba, req_row, req_col)));
            end
        end
        for (int k = 1; k <= 54; k++) begin
            step();
            req_valid = 1'b0;
            chk($sformatf("bp2_ready_%0d", k), 640'(req_ready), 640'(k == 54));
        end

        // Reset during write beat 3
        wd2 = rnd_line();
        issue(1'b1, 2'd0, 2'd2, 17'd5, 10'd8, wd2, 1'b0, t0);
        for (int k = 1; k <= 30; k++) begin
            step();
            req_valid = 1'b0;
        end
        chk("ab_oe_b3", 640'(dq_oe), 640'(1));
        chk("ab_dq_b3", 640'(dq_out), 640'(wd2[3*DQW +: DQW]));
        reset = 1'b1;
        step();
        chk("ab_oe", 640'(dq_oe), 640'(0));
        chk("ab_dq", 640'(dq_out), 640'(0));
        chk("ab_cs_n", 640'(cs_n), 640'(1));
        chk("ab_act_n", 640'(act_n), 640'(1));
        chk("ab_A", 640'(A), 640'(0));
        chk("ab_dqs_c", 640'(dqs_c), 640'(18'h3FFFF));
        chk("ab_rvalid", 640'(rdata_valid), 640'(0));
        chk("ab_ready", 640'(req_ready), 640'(0));
        step();
        reset = 1'b0;
        step();
        chk("ab_ready_after", 640'(req_ready), 640'(1));
        for (int k = 0; k < 5; k++) step();

        // New write after abort, then read it back
        wd3 = rnd_line();
        issue(1'b1, 2'd0, 2'd2, 17'd5, 10'd8, wd3, 1'b1, t0);
        for (int k = 1; k <= 62; k++) begin
            step();
            req_valid = 1'b0;
        end
        chk("w3_ready", 640'(req_ready), 640'(1));
        rd_q.push_back(wd3);
        issue(1'b0, 2'd0, 2'd2, 17'd5, 10'd8, '0, 1'b1, t0);
        for (int k = 1; k <= 54; k++) begin
            step();
            req_valid = 1'b0;
        end
        chk("r3_ready", 640'(req_ready), 640'(1));

        // Minimum timing: read
        mline = MBW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        chk("m_ready_rd", 640'(m_req_ready), 640'(1));
        m_req_write = 1'b0; m_req_bg = 2'd1; m_req_ba = 2'd2;
        m_req_row = 17'd3; m_req_col = 10'd4; m_req_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            m_req_valid = 1'b0;
            if (k == 3) m_dq_in = mline[DQW-1:0];
            else if (k == 4) m_dq_in = mline[MBW-1:DQW];
            else m_dq_in = JUNK;
            chk($sformatf("m_rd_cs_%0d", k), 640'(m_cs_n),
                640'((k == 1 || k == 2 || k == 5) ? 1'b0 : 1'b1));
            chk($sformatf("m_rd_rv_%0d", k), 640'(m_rdata_valid), 640'(k == 5));
            chk($sformatf("m_rd_rdy_%0d", k), 640'(m_req_ready), 640'(k == 6));
            if (k == 1) chk("m_rd_act_A", 640'({m_act_n, m_A}), 640'({1'b0, 17'd3}));
            if (k == 2) chk("m_rd_cas_A", 640'({m_act_n, m_A}), 640'({1'b1, 17'h14004}));
            if (k == 5) begin
                chk("m_rd_pre_A", 640'({m_act_n, m_A}), 640'({1'b1, 17'h08000}));
                chk("m_rdata", 640'(m_rdata), 640'(mline));
            end
        end

        // Minimum timing: write
        m_req_wdata = MBW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        m_req_write = 1'b1; m_req_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            m_req_valid = 1'b0;
            chk($sformatf("m_wr_cs_%0d", k), 640'(m_cs_n),
                640'((k == 1 || k == 2 || k == 5) ? 1'b0 : 1'b1));
            chk($sformatf("m_wr_oe_%0d", k), 640'(m_dq_oe), 640'(k == 3 || k == 4));
            chk($sformatf("m_wr_rdy_%0d", k), 640'(m_req_ready), 640'(k == 6));
            if (k == 2) chk("m_wr_cas_A", 640'(m_A), 640'(17'h10004));
            if (k == 3) chk("m_wr_b0", 640'(m_dq_out), 640'(m_req_wdata[DQW-1:0]));
            if (k == 4) chk("m_wr_b1", 640'(m_dq_out), 640'(m_req_wdata[MBW-1:DQW]));
            if (k == 5) begin
                chk("m_wr_pre_A", 640'(m_A), 640'(17'h08000));
                chk("m_wr_dq0", 640'(m_dq_out), 640'(0));
            end
        end

        chk("cmdq_empty", 640'(cmd_q.size()), 640'(0));
        chk("rdq_empty", 640'(rd_q.size()), 640'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr4_cmd_sequencer.md
Name: ddr4_cmd_sequencer

Overview:
- Synthesizable host-side DDR4 initiator that drives the `dimm` emulation model's command/address and data pins.
- Accepts one single-burst read or write request at a time from a simple valid/ready front end.
- Issues ACT, then RD/WR, then PRE on the DDR4 pins, honouring programmable tRCD/tCL/tCWL/tWR/tRP cycle counts.
- Captures or drives the BL-beat data burst and reports completion. It replaces hand-timed bench stimulus and is the basis of the emulator's memory-controller front end.

Parameters:
- RANKS, 1, number of ranks (cs_n width)
- CHIPS, 18, devices per rank (dqs width)
- BGWIDTH, 2, bank-group address bits
- BAWIDTH, 2, bank address bits
- ADDRWIDTH, 17, A bus width; must be >=17 (command bits fixed at A[16:14])
- COLWIDTH, 10, column bits, driven on A[COLWIDTH-1:0]
- DEVICE_WIDTH, 4, DQ bits per device; DQWIDTH = DEVICE_WIDTH*CHIPS
- BL, 8, burst length in beats
- TRCD, 15, ACT-to-CAS cycles (>=1)
- TCL, 15, RD-to-first-read-beat cycles (>=1)
- TCWL, 11, WR-to-first-write-beat cycles (>=1)
- TWR, 12, cycles after last write beat +1 before PRE (>=0)
- TRP, 15, PRE-to-ready cycles (>=1)
- CNTW, 8, wait-counter width; all timing params must be < 2**CNTW

Ports:
- clk  in  1  sequencer and DDR command clock (one command slot per cycle)
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle and able to accept
- req_write  in  1  1 = write, 0 = read
- req_rank  in  max(1,$clog2(RANKS))  target rank
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row address
- req_col  in  COLWIDTH  column address
- req_wdata  in  DQWIDTH*BL  write burst; beat k = [k*DQWIDTH +: DQWIDTH]
- rdata  out  DQWIDTH*BL  read burst, same beat packing
- rdata_valid  out  1  one-cycle pulse, rdata valid
- cs_n  out  RANKS  chip selects
- act_n  out  1  DDR4 ACT_n
- A  out  ADDRWIDTH  address / command bits
- bg  out  BGWIDTH  bank group
- ba  out  BAWIDTH  bank
- dq_out  out  DQWIDTH  write data
- dq_oe  out  1  DQ/DQS output enable (top level tristates)
- dq_in  in  DQWIDTH  read data from DQ pins
- dqs_t  out  CHIPS  write strobe true
- dqs_c  out  CHIPS  write strobe complement

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: cs_n all 1, act_n 1, A 0, bg 0, ba 0, dq_out 0, dq_oe 0, dqs_t all 0, dqs_c all 1, rdata 0, rdata_valid 0, req_ready 0.
- req_ready goes 1 in the first cycle after reset deasserts.
- States: IDLE, ACT, TRCD_WAIT, CAS, LAT_WAIT, DATA, WR_RECOV, PRE, TRP_WAIT.
- IDLE: req_ready=1. Handshake when req_valid&&req_ready in cycle T0. Latch all req_* into internal registers; req_ready falls in T0+1. Inputs are ignored while req_ready=0.
- ACT, cycle T0+1:
  - cs_n[req_rank]=0, act_n=0, A=row, bg/ba=request.
  - Lasts exactly one cycle.
- Command/address hold rule:
  - Every non-command cycle is a DES cycle: cs_n all 1, act_n 1, A 0.
  - bg/ba hold the request value from ACT through PRE; they return to 0 in IDLE.
- CAS, cycle T0+1+TRCD:
  - cs_n[rank]=0, act_n=1.
  - A[16:14]=100 for WR, 101 for RD; A[10]=0 (no auto-precharge); A[COLWIDTH-1:0]=col; all other bits 0.
- Data beats occupy BL consecutive cycles starting CAS+TCL (read) or CAS+TCWL (write).
- Write beats:
  - dq_oe=1, dqs_t all 1, dqs_c all 0, dq_out=beat k.
  - After the last beat, in the same cycle dq_oe drops: dq_oe=0, dq_out=0, dqs_t all 0, dqs_c all 1.
- Read beats:
  - dq_in is sampled into rdata beat k on each beat cycle.
  - rdata_valid pulses for exactly one cycle, the cycle after the last beat.
  - rdata holds its value until the next read completes.
- PRE timing:
  - Read: PRE in the cycle after the last beat.
  - Write: PRE at last beat +1+TWR.
  - PRE encoding: cs_n[rank]=0, act_n=1, A[16:14]=010, rest 0.
- TRP_WAIT: req_ready returns to 1 at PRE+TRP.
- A single down-counter (CNTW bits) times each wait. Beat index is a $clog2(BL)-bit counter; it wraps only at burst end.
- Reset in any state: next cycle all outputs take reset values (DQ released, no partial PRE). In-flight request dropped; rdata_valid is not pulsed.
- Out-of-range req_rank (>=RANKS): no cs_n bit is asserted; the request is sequenced normally.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> cs_n=1, act_n=1, A=0, dq_oe=0, dqs_c=all 1, rdata_valid=0, req_ready=0; req_ready=1 one cycle after release.
- Write, defaults (bg=1, ba=1, row=1, col=2), accept at T0:
  - ACT at T0+1 with A=17'h00001.
  - WR at T0+16 with A=17'h10002.
  - dq_oe=1 over T0+27..T0+34, with dq_out beat0=req_wdata[71:0].
  - PRE at T0+47 with A=17'h08000.
  - req_ready=1 at T0+62.
- Read back same address, DIMM model attached:
  - RD at T0+16 with A=17'h14002.
  - Samples over T0+31..T0+38.
  - rdata_valid at T0+39, rdata equal to the written burst.
  - PRE at T0+39, ready at T0+54.
- Back-pressure: req_valid held high with changing fields during a read -> exactly one ACT per handshake; second request's fields are those present at its accept cycle.
- Reset asserted during write beat 3 -> next cycle dq_oe=0, cs_n all 1, no PRE issued; req_ready=1 the cycle after reset drops; a new write then completes correctly.
- Minimum timing (TRCD=TCL=TCWL=TRP=1, TWR=0, BL=2):
  - Read: ACT T0+1, RD T0+2, beats T0+3..T0+4, rdata_valid/PRE T0+5, ready T0+6.
